// File: rtl/idwt_detail_upsampler.sv
// idwt_detail_upsampler: buffers detail coefficients in a small FIFO,
// thresholds each coefficient as it is popped, and upsamples by 2 with
// zero insertion. One output sample is produced per clk_enable pulse.
//
// Build option: define IDWT_UPS_SOFT_THR_EN for soft thresholding.
// Without it, the block uses hard thresholding.
//
// Handshake: a coefficient transfers on any clk edge where coef_valid and
// coef_ready are both high. coef_ready depends only on registered FIFO
// state and on reset, so it never depends on coef_valid. The read side has
// no handshake. It consumes one slot on each clk_enable edge.
//
// phase_state is a debug view of the phase FSM: 0 = EVEN, 1 = ODD.
module idwt_detail_upsampler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic signed [15:0] coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  input  logic [14:0]        thr,
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               underrun,
  output logic [AW:0]        fifo_level,
  output logic               phase_state
);

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_t;

  phase_t phase_q;
  phase_t phase_d;

  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic signed [15:0] head;
  logic signed [16:0] x_ext;
  logic signed [16:0] t_ext;
  logic signed [16:0] x_abs;
  logic signed [15:0] thr_result;
`ifdef IDWT_UPS_SOFT_THR_EN
  logic signed [16:0] shrunk;
`endif

  logic signed [15:0] out_d;
  logic               out_valid_d;
  logic               underrun_d;

  // full and empty come from registered state only.
  assign full        = (fifo_level == (AW+1)'(DEPTH));
  assign empty       = (fifo_level == '0);
  assign coef_ready  = !reset && !full;
  assign push        = coef_valid && coef_ready;
  assign head        = mem[rd_ptr];
  assign phase_state = phase_q;

  // Threshold the FIFO head in 17-bit signed arithmetic.
  // |x| for x = -32768 is +32768, and that value fits in 17 bits.
  always_comb begin
    x_ext      = {head[15], head};
    t_ext      = {2'b00, thr};
    x_abs      = x_ext[16] ? -x_ext : x_ext;
    thr_result = '0;
`ifdef IDWT_UPS_SOFT_THR_EN
    shrunk     = x_ext[16] ? (x_ext + t_ext) : (x_ext - t_ext);
    if (x_abs > t_ext) thr_result = shrunk[15:0];
`else
    if (x_abs > t_ext) thr_result = head;
`endif
  end

  // Phase FSM: the next phase, the pop decision, and the next output-slot values.
  always_comb begin
    phase_d     = phase_q;
    pop         = 1'b0;
    out_d       = out;
    out_valid_d = out_valid;
    underrun_d  = underrun;
    if (clk_enable) begin
      case (phase_q)
        PH_EVEN: begin
          phase_d = PH_ODD;
          if (!empty) begin
            pop         = 1'b1;
            out_d       = thr_result;
            out_valid_d = 1'b1;
          end else begin
            out_d       = '0;
            out_valid_d = 1'b0;
            underrun_d  = 1'b1;
          end
        end
        PH_ODD: begin
          phase_d     = PH_EVEN;
          out_d       = '0;
          out_valid_d = 1'b0;
        end
        default: begin
          phase_d     = PH_EVEN;
          out_d       = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Phase register, output slot register and sticky underrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_EVEN;
      out       <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      underrun  <= underrun_d;
    end
  end

  // FIFO storage. Reset discards contents by clearing the pointers, not the RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= coef_in;
  end

  // FIFO pointers and fill level. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_idwt_detail_upsampler.sv
// Testbench for idwt_detail_upsampler. A queue-based reference model tracks
// the FIFO contents, the output slot and the underrun flag. A compare
// process checks every DUT output against the model on each falling edge.
// Directed sections also pin literal values.
module tb_idwt_detail_upsampler;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic               clk;
  logic               reset;
  logic               clk_enable;
  logic signed [15:0] coef_in;
  logic               coef_valid;
  logic               coef_ready;
  logic [14:0]        thr;
  logic signed [15:0] out;
  logic               out_valid;
  logic               underrun;
  logic [AW:0]        fifo_level;
  logic               phase_state;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [15:0] exp_q[$];
  logic        m_phase_odd;
  logic [15:0] m_out;
  logic        m_out_valid;
  logic        m_underrun;
  bit          chk_en = 0;

  idwt_detail_upsampler #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .thr        (thr),
    .out        (out),
    .out_valid  (out_valid),
    .underrun   (underrun),
    .fifo_level (fifo_level),
    .phase_state(phase_state)
  );

  // Clock and reset
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Threshold rule applied to a plain integer value.
  function automatic logic [15:0] thresh(input logic [15:0] c, input logic [14:0] t);
    int x, a, ti, r;
    x  = int'($signed(c));
    ti = int'(t);
    a  = (x < 0) ? -x : x;
    if (a <= ti) r = 0;
`ifdef IDWT_UPS_SOFT_THR_EN
    else if (x > 0) r = x - ti;
    else r = x + ti;
`else
    else r = x;
`endif
    return r[15:0];
  endfunction

  // Model update on each active edge, computed from the inputs applied before that edge.
  always @(posedge clk) begin
    int  sz;
    bit  acc;
    sz  = exp_q.size();
    acc = coef_valid && !reset && (sz < DEPTH);
    if (reset) begin
      exp_q.delete();
      m_phase_odd = 0;
      m_out       = 0;
      m_out_valid = 0;
      m_underrun  = 0;
    end else begin
      if (clk_enable) begin
        if (!m_phase_odd) begin
          if (sz > 0) begin
            m_out       = thresh(exp_q.pop_front(), thr);
            m_out_valid = 1;
          end else begin
            m_out       = 0;
            m_out_valid = 0;
            m_underrun  = 1;
          end
        end else begin
          m_out       = 0;
          m_out_valid = 0;
        end
        m_phase_odd = !m_phase_odd;
      end
      if (acc) exp_q.push_back(coef_in);
    end
  end

  // Compare process: check every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out",        32'($signed(out)), 32'($signed(m_out)));
      chk("out_valid",  32'(out_valid), 32'(m_out_valid));
      chk("underrun",   32'(underrun), 32'(m_underrun));
      chk("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("coef_ready", 32'(coef_ready), 32'(!reset && exp_q.size() < DEPTH));
      chk("phase",      32'(phase_state), 32'(m_phase_odd));
    end
  end

  // Driver tasks. Inputs change 2 time units after the rising edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic push(input logic [15:0] v);
    coef_in = v; coef_valid = 1;
    @(posedge clk); #2;
    coef_valid = 0;
  endtask

  task automatic pulse();
    clk_enable = 1;
    @(posedge clk); #2;
    clk_enable = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    idle(n);
    reset = 0;
  endtask

  // Directed and random stimulus
  initial begin
    reset = 1; clk_enable = 0; coef_valid = 1; coef_in = 16'h1234; thr = 0;
    @(posedge clk); #2;
    chk_en = 1;
    // Reset held for 3 cycles with coef_valid driven high.
    idle(2);
    chk("rst_ready", 32'(coef_ready), 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_out",   32'($signed(out)), 0);
    chk("rst_ovld",  32'(out_valid), 0);
    chk("rst_under", 32'(underrun), 0);
    reset = 0; coef_valid = 0;
    idle(1);
    chk("post_rst_level", 32'(fifo_level), 0);

    // Basic upsample.
    push(16'd100); push(-16'sd200); push(16'd300);
    pulse(); chk("basic0", 32'($signed(out)), 100);  chk("basic0_v", 32'(out_valid), 1);
    pulse(); chk("basic1", 32'($signed(out)), 0);    chk("basic1_v", 32'(out_valid), 0);
    pulse(); chk("basic2", 32'($signed(out)), -200); chk("basic2_v", 32'(out_valid), 1);
    pulse(); chk("basic3", 32'($signed(out)), 0);
    pulse(); chk("basic4", 32'($signed(out)), 300);
    pulse(); chk("basic5", 32'($signed(out)), 0);
    chk("basic_under", 32'(underrun), 0);

    // Threshold with T = 50.
    thr = 15'd50;
    push(16'd40); push(-16'sd120); push(16'd75); push(16'd50);
`ifdef IDWT_UPS_SOFT_THR_EN
    pulse(); chk("thr40", 32'($signed(out)), 0);    pulse();
    pulse(); chk("thr-120", 32'($signed(out)), -70); pulse();
    pulse(); chk("thr75", 32'($signed(out)), 25);   pulse();
    pulse(); chk("thr50", 32'($signed(out)), 0);    pulse();
`else
    pulse(); chk("thr40", 32'($signed(out)), 0);     pulse();
    pulse(); chk("thr-120", 32'($signed(out)), -120); pulse();
    pulse(); chk("thr75", 32'($signed(out)), 75);    pulse();
    pulse(); chk("thr50", 32'($signed(out)), 0);     pulse();
`endif
    // x = -32768 with T = 0 passes through unchanged.
    thr = 0;
    push(16'h8000);
    pulse(); chk("thr_min", 32'($signed(out)), -32768); pulse();

    // Full and backpressure: offer 10 coefficients with no clk_enable.
    for (int i = 0; i < 10; i++) push(16'(i + 1));
    chk("full_level", 32'(fifo_level), 8);
    chk("full_ready", 32'(coef_ready), 0);
    pulse();
    chk("unfull_ready", 32'(coef_ready), 1);
    chk("unfull_out", 32'($signed(out)), 1);
    for (int i = 0; i < 15; i++) pulse();
    chk("drained", 32'(fifo_level), 0);

    // Underrun.
    pulse(); chk("und_out0", 32'($signed(out)), 0); chk("und_flag", 32'(underrun), 1);
    pulse(); chk("und_out1", 32'($signed(out)), 0);
    push(16'd77);
    pulse(); chk("und_later", 32'($signed(out)), 77); chk("und_sticky", 32'(underrun), 1);
    pulse();
    do_reset(1);
    chk("und_cleared", 32'(underrun), 0);

    // Mid-operation reset with fifo_level = 5 and phase ODD.
    for (int i = 0; i < 6; i++) push(16'(200 + i));
    pulse();
    chk("mid_level", 32'(fifo_level), 5);
    chk("mid_phase", 32'(phase_state), 1);
    do_reset(1);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_phase", 32'(phase_state), 0);
    push(16'd555);
    pulse();
    chk("mid_new", 32'($signed(out)), 555);
    chk("mid_new_v", 32'(out_valid), 1);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      coef_valid = ($urandom_range(0, 99) < 45);
      coef_in    = 16'($urandom);
      clk_enable = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 9) == 0) thr = 15'($urandom_range(0, 40000));
      reset      = ($urandom_range(0, 299) == 0);
      @(posedge clk); #2;
    end
    reset = 0; coef_valid = 0; clk_enable = 0;
    idle(2);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
